// File: rtl/i3c_scl_phase_ctrl.sv
// SCL pulse-train generator: times low/high phases through an external down-counter
// and waits for the sampled bus level to rise before timing each high phase.
module i3c_scl_phase_ctrl #(
   parameter int CNTR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_i,
   output logic              req_ready_o,
   input  logic [3:0]        nbits_i,
   input  logic [CNTR_W-1:0] t_low_i,
   input  logic [CNTR_W-1:0] t_high_i,
   input  logic              abort_i,
   input  logic              scl_i,
   output logic              scl_o,
   output logic              tmr_load_o,
   output logic [CNTR_W-1:0] tmr_value_o,
   input  logic              tmr_expired_i,
   output logic              bit_strobe_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOW       = 2'd1,
      S_WAIT_HIGH = 2'd2,
      S_HIGH      = 2'd3
   } state_e;

   // Handshake: a request is taken in the cycle where req_i && req_ready_o;
   // ready is only offered in IDLE and never while abort_i is high.

   state_e              state_q, state_d;
   logic [3:0]          bits_q, bits_d;
   logic [CNTR_W-1:0]   t_low_q, t_low_d;
   logic [CNTR_W-1:0]   t_high_q, t_high_d;
   logic                done_q, done_d;

   logic                load;
   logic [CNTR_W-1:0]   value;
   logic                strobe;
   logic                ready;
   logic [3:0]          nbits_clamped;

   assign nbits_clamped = (nbits_i > 4'd9) ? 4'd9 : nbits_i;

   always_comb begin
      state_d  = state_q;
      bits_d   = bits_q;
      t_low_d  = t_low_q;
      t_high_d = t_high_q;
      done_d   = 1'b0;
      load     = 1'b0;
      value    = '0;
      strobe   = 1'b0;
      ready    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready = !abort_i;
            if (req_i && ready) begin
               t_low_d  = t_low_i;
               t_high_d = t_high_i;
               bits_d   = nbits_clamped;
               if (nbits_clamped != 4'd0) begin
                  load    = 1'b1;
                  value   = t_low_i;
                  state_d = S_LOW;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         S_LOW: begin
            if (abort_i) begin
               state_d = S_IDLE;
               bits_d  = 4'd0;
            end else if (tmr_expired_i) begin
               state_d = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            // The timer free-runs here; only the bus level matters while a target stretches.
            if (abort_i) begin
               state_d = S_IDLE;
               bits_d  = 4'd0;
            end else if (scl_i) begin
               load    = 1'b1;
               value   = t_high_q;
               strobe  = 1'b1;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (abort_i) begin
               state_d = S_IDLE;
               bits_d  = 4'd0;
            end else if (tmr_expired_i) begin
               bits_d = bits_q - 4'd1;
               if (bits_q > 4'd1) begin
                  load    = 1'b1;
                  value   = t_low_q;
                  state_d = S_LOW;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            bits_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         bits_q   <= 4'd0;
         t_low_q  <= '0;
         t_high_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bits_q   <= bits_d;
         t_low_q  <= t_low_d;
         t_high_q <= t_high_d;
         done_q   <= done_d;
      end
   end

   // Combinational strobes are masked while reset is held so the pad/timer see quiet inputs.
   assign tmr_load_o   = rst_n & load;
   assign tmr_value_o  = rst_n ? value : '0;
   assign bit_strobe_o = rst_n & strobe;
   assign req_ready_o  = rst_n & ready;
   assign scl_o        = (state_q != S_LOW);
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = done_q;

endmodule

// File: tb/tb_i3c_scl_phase_ctrl.sv
// Bench for i3c_scl_phase_ctrl: models the load/expire timer and a stretching target,
// and compares every cycle of each train against a trace built from the phase-length rules.
module tb_i3c_scl_phase_ctrl;
  localparam int W = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_i = 1'b0;
  logic          req_ready_o;
  logic [3:0]    nbits_i = '0;
  logic [W-1:0]  t_low_i = '0;
  logic [W-1:0]  t_high_i = '0;
  logic          abort_i = 1'b0;
  logic          scl_i;
  logic          scl_o;
  logic          tmr_load_o;
  logic [W-1:0]  tmr_value_o;
  logic          tmr_expired_i;
  logic          bit_strobe_o;
  logic          busy_o;
  logic          done_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  i3c_scl_phase_ctrl #(.CNTR_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .req_ready_o   (req_ready_o),
    .nbits_i       (nbits_i),
    .t_low_i       (t_low_i),
    .t_high_i      (t_high_i),
    .abort_i       (abort_i),
    .scl_i         (scl_i),
    .scl_o         (scl_o),
    .tmr_load_o    (tmr_load_o),
    .tmr_value_o   (tmr_value_o),
    .tmr_expired_i (tmr_expired_i),
    .bit_strobe_o  (bit_strobe_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // ---------------- external timer: load N at t -> expired at t+N+1 ----------------
  logic [W-1:0] tmr_cnt = '1;
  always @(posedge clk) begin
    if (!rst_n)          tmr_cnt <= '1;
    else if (tmr_load_o) tmr_cnt <= tmr_value_o;
    else                 tmr_cnt <= tmr_cnt - 1'b1;
  end
  assign tmr_expired_i = (tmr_cnt == '0);

  // ---------------- target: holds SCL low stretch_arr[bit] cycles after each LOW ----------------
  int stretch_arr[9];
  int bit_idx = 0;
  int hold = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      hold    <= 0;
      bit_idx <= 0;
    end else begin
      if (req_i && req_ready_o) bit_idx <= 0;
      else if (bit_strobe_o)    bit_idx <= bit_idx + 1;
      if (!scl_o)               hold <= stretch_arr[bit_idx];
      else if (hold != 0)       hold <= hold - 1;
    end
  end
  assign scl_i = scl_o && (hold == 0);

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int train_no = 0;

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got scl/busy/ld/stb/done/rdy/val=%b expected %b", tag, obs, exp);
  endtask

  function automatic logic [14:0] word(bit scl, bit busy, bit ld, bit stb, bit dn, bit rdy, int v);
    logic [W-1:0] vv;
    vv = W'(v);
    return {scl, busy, ld, stb, dn, rdy, vv};
  endfunction

  function automatic logic [14:0] obs_word();
    return {scl_o, busy_o, tmr_load_o, bit_strobe_o, done_o, req_ready_o, tmr_value_o};
  endfunction

  // Expected trace from acceptance cycle through the done cycle, from phase lengths alone.
  task automatic build(input int n, input int tl, input int th);
    int ne;
    ne = (n > 9) ? 9 : n;
    exp_q.delete();
    if (ne == 0) begin
      exp_q.push_back(word(1, 0, 0, 0, 0, 1, 0));
    end else begin
      exp_q.push_back(word(1, 0, 1, 0, 0, 1, tl));
      for (int b = 0; b < ne; b++) begin
        for (int k = 0; k <= tl; k++)           exp_q.push_back(word(0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < stretch_arr[b]; k++) exp_q.push_back(word(1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(word(1, 1, 1, 1, 0, 0, th));
        for (int k = 0; k < th; k++)            exp_q.push_back(word(1, 1, 0, 0, 0, 0, 0));
        if (b < ne - 1) exp_q.push_back(word(1, 1, 1, 0, 0, 0, tl));
        else            exp_q.push_back(word(1, 1, 0, 0, 0, 0, 0));
      end
    end
    exp_q.push_back(word(1, 0, 0, 0, 1, 1, 0));
  endtask

  // ---------------- driver ----------------
  // stretch < 0: random per bit; abort_at/rst_at: -1 none, -2 random, else fixed cycle index.
  task automatic run_train(input int n, input int tl, input int th, input int stretch,
                           input int abort_at, input int rst_at);
    int len;
    int ab;
    int rs;
    logic [14:0] exp;
    for (int b = 0; b < 9; b++) stretch_arr[b] = (stretch < 0) ? int'($urandom_range(0, 6)) : stretch;
    build(n, tl, th);
    len = exp_q.size();
    ab = abort_at;
    rs = rst_at;
    if (ab == -2) ab = (len >= 3) ? int'($urandom_range(1, len - 2)) : -1;
    if (rs == -2) rs = (len >= 3) ? int'($urandom_range(1, len - 2)) : -1;
    train_no++;
    for (int cyc = 0; cyc < len; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        req_i = 1'b1; nbits_i = 4'(n); t_low_i = W'(tl); t_high_i = W'(th);
      end else begin
        req_i = 1'b0;
        nbits_i = 4'($urandom_range(0, 15));
        t_low_i = W'($urandom_range(0, 511));
        t_high_i = W'($urandom_range(0, 511));
      end
      exp = exp_q.pop_front();
      if (cyc == ab) begin
        abort_i = 1'b1;
        exp[12] = 1'b0; exp[11] = 1'b0; exp[W-1:0] = '0;
        #1 check($sformatf("t%0d_abort_cycle", train_no), obs_word(), exp);
        @(negedge clk);
        abort_i = 1'b0;
        #1 check($sformatf("t%0d_after_abort", train_no), obs_word(), word(1, 0, 0, 0, 0, 1, 0));
        return;
      end
      if (cyc == rs) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1 check($sformatf("t%0d_mid_reset", train_no), obs_word(), word(1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check($sformatf("t%0d_after_reset", train_no), obs_word(), word(1, 0, 0, 0, 0, 1, 0));
        return;
      end
      #1 check($sformatf("t%0d_cyc%0d", train_no, cyc), obs_word(), exp);
    end
    @(negedge clk);
    #1 check($sformatf("t%0d_idle", train_no), obs_word(), word(1, 0, 0, 0, 0, 1, 0));
  endtask

  initial begin
    for (int b = 0; b < 9; b++) stretch_arr[b] = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset_values", obs_word(), word(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_after_reset", obs_word(), word(1, 0, 0, 0, 0, 1, 0));

    run_train(1, 3, 2, 0, -1, -1);
    run_train(2, 3, 2, 0, -1, -1);
    run_train(1, 3, 2, 5, -1, -1);
    run_train(9, 5, 4, 0, 2, -1);
    run_train(0, 7, 7, 0, -1, -1);
    run_train(12, 1, 1, 0, -1, -1);
    run_train(1, 3, 2, 0, -1, 7);
    run_train(1, 3, 2, 0, -1, -1);
    run_train(3, 0, 0, 0, -1, -1);
    run_train(2, 0, 0, 3, -1, -1);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      run_train(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 12)), -1,
                (sel == 0) ? -2 : -1, (sel == 1) ? -2 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
